mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Memory-side responder for the CPU's memory data/address path: services read and write requests issued by the MDR/MAR control logic.
- Holds a synchronous word-addressed RAM array and inserts a configurable number of wait states.
- Returns read data to the MDR's memory-side input, then signals completion with a one-cycle ready pulse.
- Sits between the datapath (MAR address, MDR data) and nothing further; it is the memory endpoint of the system.

Parameters:
- DATA_WIDTH, 32, word width of the data lines.
- ADDR_WIDTH, 9, address width taken from MAR.
- DEPTH, 512, number of implemented words; DEPTH <= 2**ADDR_WIDTH.
- LATENCY, 2, wait states between acceptance and access; 0 is legal.

Ports:
- clock, in, 1: single system clock, rising edge.
- clear, in, 1: asynchronous, active-low reset.
- mem_read, in, 1: read request, level.
- mem_write, in, 1: write request, level.
- mem_addr, in, ADDR_WIDTH: word address from MAR.
- mem_data_in, in, DATA_WIDTH: write data from MDR.
- mem_data_out, out, DATA_WIDTH: read data to MDR memory-side input.
- mem_ready, out, 1: one-cycle completion pulse.
- mem_busy, out, 1: high whenever state != IDLE.
- mem_error, out, 1: valid with mem_ready; flags a rejected request.

Behaviour:
- Reset (clear=0, async):
  - state -> IDLE; mem_data_out=0, mem_ready=0, mem_busy=0, mem_error=0; counter=0.
  - RAM contents are not cleared.
- States: IDLE, WAIT, RESP.
- IDLE:
  - Request accepted at rising edge k when mem_read|mem_write=1.
  - At acceptance, latch op, mem_addr and mem_data_in into internal registers. Later input changes have no effect.
  - LATENCY=0: perform the access at edge k, go to RESP.
  - LATENCY>0: go to WAIT with counter=LATENCY-1.
- WAIT:
  - counter!=0: decrement.
  - counter==0: perform the access on this edge, go to RESP.
- RESP:
  - mem_ready=1 for exactly one cycle, then -> IDLE at the next edge.
- Timing: mem_ready is high in the cycle following edge k+LATENCY.
  - Earliest next acceptance is edge k+LATENCY+2.
  - Requests asserted while in WAIT or RESP are ignored and not queued.
- Requester rule: drop the request on seeing mem_ready. A request still high in IDLE is treated as a new request.
- Read access:
  - mem_data_out <= RAM[addr_q].
  - Held stable until the next successful read completes. Writes and errors do not change it.
- Write access: RAM[addr_q] <= data_q; mem_data_out unchanged.
- Error cases (transaction still runs the full LATENCY, ends in RESP with mem_error=1 alongside mem_ready):
  - mem_read and mem_write both 1 at acceptance: no access.
  - addr_q >= DEPTH: write dropped; read leaves mem_data_out unchanged.
- mem_error=0 in all cycles other than an erroring RESP.
- Reset mid-transaction: transaction abandoned, no RAM write, outputs to reset values.
- Counter width: clog2(LATENCY+1), minimum 1 bit.

Decomposition:
- Shared package mem_pkg holds:
  - state enum (IDLE=2'd0, WAIT=2'd1, RESP=2'd2);
  - default DATA_WIDTH and ADDR_WIDTH constants, shared with MDR/MAR.
- One sub-module, mem_array:
  - single-port synchronous RAM (DEPTH x DATA_WIDTH), with write enable, address, data in, and registered data out on read enable;
  - the FSM, counter and error logic stay in the top level.

Test Plan:
- LATENCY=2. Write 0xDEADBEEF to addr 0x010 at edge 1 -> mem_busy high cycles 1-3, mem_ready pulse in cycle after edge 3, mem_error=0. Then read 0x010 -> mem_data_out=0xDEADBEEF with mem_ready.
- LATENCY=0. Back-to-back writes to 0x001 (0x11111111) and 0x002 (0x22222222), then reads of both -> ready one cycle after each acceptance; data read back matches. mem_read held through RESP is not double-accepted.
- mem_read=mem_write=1 at addr 0x005 -> mem_ready with mem_error=1 after LATENCY+1 cycles. RAM[0x005] and mem_data_out unchanged.
- DEPTH=256, ADDR_WIDTH=9. Write 0xCAFEF00D to 0x100 -> mem_error=1. A read of 0x000 returns the prior value, proving no aliasing.
- Reset asserted during WAIT of a write to 0x020 (old value 0x12345678) -> outputs zero immediately (async). After release, read 0x020 returns 0x12345678.
- Change mem_addr and mem_data_in during WAIT -> access uses the values latched at acceptance.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder and the MDR/MAR datapath.
// Holds the FSM state encoding, default bus widths and width helpers.
package mem_pkg;

  localparam int MEM_DATA_WIDTH = 32;
  localparam int MEM_ADDR_WIDTH = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Wait-state counter must hold LATENCY-1; never narrower than one bit.
  function automatic int cnt_width(input int latency);
    return (latency < 2) ? 1 : $clog2(latency + 1);
  endfunction

  function automatic int idx_width(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bus between the MDR/MAR control logic and the memory responder.
// The master is the datapath requester, the slave is the memory endpoint.
interface mem_responder_if
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = MEM_DATA_WIDTH,
  parameter int ADDR_WIDTH = MEM_ADDR_WIDTH
);

  logic                  mem_read;
  logic                  mem_write;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_data_in;
  logic [DATA_WIDTH-1:0] mem_data_out;
  logic                  mem_ready;
  logic                  mem_busy;
  logic                  mem_error;

  modport master (
    output mem_read, mem_write, mem_addr, mem_data_in,
    input  mem_data_out, mem_ready, mem_busy, mem_error
  );

  modport slave (
    input  mem_read, mem_write, mem_addr, mem_data_in,
    output mem_data_out, mem_ready, mem_busy, mem_error
  );

endinterface

// File: rtl/mem_array.sv
// Single-port synchronous RAM with a registered read port.
// The storage is never reset; only the read-data register clears on reset.
module mem_array
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = MEM_DATA_WIDTH,
  parameter int DEPTH      = 512,
  parameter int IDX_W      = idx_width(DEPTH)
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  i_we,
  input  logic                  i_re,
  input  logic [IDX_W-1:0]      i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  always_ff @(posedge clock) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  // Read register only loads on a successful read, so it holds between reads.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_responder.sv
// Memory endpoint for the MDR/MAR path: accepts one request at a time,
// inserts LATENCY wait states, performs the access and pulses mem_ready.
module mem_responder
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = MEM_DATA_WIDTH,
  parameter int ADDR_WIDTH = MEM_ADDR_WIDTH,
  parameter int DEPTH      = 512,
  parameter int LATENCY    = 2
) (
  input logic             clock,
  input logic             clear,
  mem_responder_if.slave  bus
);

  localparam int CNT_W = cnt_width(LATENCY);
  localparam int IDX_W = idx_width(DEPTH);
  localparam logic [CNT_W-1:0]    CNT_LOAD = (LATENCY > 0) ? CNT_W'(LATENCY - 1) : '0;
  localparam logic [ADDR_WIDTH:0] DEPTH_L  = (ADDR_WIDTH + 1)'(DEPTH);

  state_t                r_state;
  logic [CNT_W-1:0]      r_count;
  logic                  r_rd;
  logic                  r_wr;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_ready;
  logic                  r_busy;
  logic                  r_error;

  logic                  w_accept;
  logic                  w_access;
  logic                  w_op_rd;
  logic                  w_op_wr;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic                  w_bad;
  logic                  w_ram_we;
  logic                  w_ram_re;
  logic [DATA_WIDTH-1:0] w_rdata;

  // With zero wait states the access happens on the accepting edge, so the
  // operands come straight from the bus instead of the capture registers.
  always_comb begin
    w_accept = (r_state == IDLE) && (bus.mem_read || bus.mem_write);
    w_access = (LATENCY == 0) ? w_accept : ((r_state == WAIT) && (r_count == '0));
    if (r_state == IDLE) begin
      w_op_rd = bus.mem_read;
      w_op_wr = bus.mem_write;
      w_addr  = bus.mem_addr;
      w_wdata = bus.mem_data_in;
    end else begin
      w_op_rd = r_rd;
      w_op_wr = r_wr;
      w_addr  = r_addr;
      w_wdata = r_data;
    end
    w_bad    = (w_op_rd && w_op_wr) || ({1'b0, w_addr} >= DEPTH_L);
    w_ram_we = w_access && w_op_wr && !w_bad;
    w_ram_re = w_access && w_op_rd && !w_bad;
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_state <= IDLE;
      r_count <= '0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      r_error <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_rd   <= bus.mem_read;
            r_wr   <= bus.mem_write;
            r_addr <= bus.mem_addr;
            r_data <= bus.mem_data_in;
            r_busy <= 1'b1;
            if (LATENCY == 0) begin
              r_state <= RESP;
              r_ready <= 1'b1;
              r_error <= w_bad;
            end else begin
              r_state <= WAIT;
              r_count <= CNT_LOAD;
            end
          end
        end
        WAIT: begin
          if (r_count == '0) begin
            r_state <= RESP;
            r_ready <= 1'b1;
            r_error <= w_bad;
          end else begin
            r_count <= r_count - CNT_W'(1);
          end
        end
        RESP: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  mem_array #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH),
    .IDX_W     (IDX_W)
  ) u_mem_array (
    .clock  (clock),
    .clear  (clear),
    .i_we   (w_ram_we),
    .i_re   (w_ram_re),
    .i_addr (w_addr[IDX_W-1:0]),
    .i_wdata(w_wdata),
    .o_rdata(w_rdata)
  );

  assign bus.mem_data_out = w_rdata;
  assign bus.mem_ready    = r_ready;
  assign bus.mem_busy     = r_busy;
  assign bus.mem_error    = r_error;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: dut_a has LATENCY=2 with DEPTH=256,
// dut_b has LATENCY=0 with DEPTH=512; both share clock and reset.
module tb_mem_responder;

  typedef struct packed {
    logic        sel;       // 0 = dut_a, 1 = dut_b
    logic        rd;
    logic        wr;
    logic [8:0]  addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_data;  // mem_data_out expected alongside mem_ready
  } vec_t;

  logic clk = 1'b0;
  logic clear = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mem_responder_if #(.DATA_WIDTH(32), .ADDR_WIDTH(9)) bus_a ();
  mem_responder_if #(.DATA_WIDTH(32), .ADDR_WIDTH(9)) bus_b ();

  mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(9), .DEPTH(256), .LATENCY(2)) dut_a (
    .clock(clk), .clear(clear), .bus(bus_a)
  );
  mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(9), .DEPTH(512), .LATENCY(0)) dut_b (
    .clock(clk), .clear(clear), .bus(bus_b)
  );

  logic [1:0]  rdy;
  logic [1:0]  bsy;
  logic [1:0]  err;
  logic [31:0] dout [2];

  assign rdy     = {bus_b.mem_ready, bus_a.mem_ready};
  assign bsy     = {bus_b.mem_busy,  bus_a.mem_busy};
  assign err     = {bus_b.mem_error, bus_a.mem_error};
  assign dout[0] = bus_a.mem_data_out;
  assign dout[1] = bus_b.mem_data_out;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h expected=%08h", name, got, exp);
    end
  endtask

  task automatic drive(input logic sel, input logic rd, input logic wr,
                       input logic [8:0] a, input logic [31:0] d);
    if (sel) begin
      bus_b.mem_read = rd; bus_b.mem_write = wr; bus_b.mem_addr = a; bus_b.mem_data_in = d;
    end else begin
      bus_a.mem_read = rd; bus_a.mem_write = wr; bus_a.mem_addr = a; bus_a.mem_data_in = d;
    end
  endtask

  // Issue one request, wait (bounded) for mem_ready, check it, then drop the request.
  task automatic run_txn(input int idx, input vec_t v);
    int cyc;
    int lat;
    lat = v.sel ? 1 : 3;
    @(negedge clk);
    drive(v.sel, v.rd, v.wr, v.addr, v.wdata);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!rdy[v.sel] && cyc < 20);
    check($sformatf("t%0d_cycles", idx), 32'(cyc), 32'(lat));
    check($sformatf("t%0d_error", idx), 32'(err[v.sel]), 32'(v.exp_err));
    check($sformatf("t%0d_data", idx), dout[v.sel], v.exp_data);
    check($sformatf("t%0d_busy", idx), 32'(bsy[v.sel]), 32'd1);
    $display("txn %0d dut=%s rd=%0b wr=%0b addr=%03h wdata=%08h -> cycles=%0d err=%0b data=%08h",
             idx, v.sel ? "b" : "a", v.rd, v.wr, v.addr, v.wdata, cyc, err[v.sel], dout[v.sel]);
    drive(v.sel, 1'b0, 1'b0, 9'h000, 32'h0);
  endtask

  vec_t vecs[$];
  vec_t v;

  initial begin
    int cyc;
    drive(1'b0, 1'b0, 1'b0, 9'h000, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 9'h000, 32'h0);

    //            sel   rd    wr    addr    wdata         err   exp_data
    vecs.push_back('{1'b0, 1'b0, 1'b1, 9'h010, 32'hDEADBEEF, 1'b0, 32'h00000000});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 9'h010, 32'h00000000, 1'b0, 32'hDEADBEEF});
    vecs.push_back('{1'b1, 1'b0, 1'b1, 9'h001, 32'h11111111, 1'b0, 32'h00000000});
    vecs.push_back('{1'b1, 1'b0, 1'b1, 9'h002, 32'h22222222, 1'b0, 32'h00000000});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 9'h001, 32'h00000000, 1'b0, 32'h11111111});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 9'h002, 32'h00000000, 1'b0, 32'h22222222});
    vecs.push_back('{1'b1, 1'b1, 1'b1, 9'h001, 32'h99999999, 1'b1, 32'h22222222});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 9'h001, 32'h00000000, 1'b0, 32'h11111111});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 9'h005, 32'h55555555, 1'b0, 32'hDEADBEEF});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 9'h005, 32'h99999999, 1'b1, 32'hDEADBEEF});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 9'h005, 32'h00000000, 1'b0, 32'h55555555});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 9'h000, 32'h0BADC0DE, 1'b0, 32'h55555555});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 9'h100, 32'hCAFEF00D, 1'b1, 32'h55555555});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 9'h000, 32'h00000000, 1'b0, 32'h0BADC0DE});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 9'h1FF, 32'h00000000, 1'b1, 32'h0BADC0DE});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 9'h020, 32'h12345678, 1'b0, 32'h0BADC0DE});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 9'h041, 32'h41414141, 1'b0, 32'h0BADC0DE});

    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      check($sformatf("reset_data_%0d", s),  dout[s],       32'h0);
      check($sformatf("reset_ready_%0d", s), 32'(rdy[s]),   32'd0);
      check($sformatf("reset_busy_%0d", s),  32'(bsy[s]),   32'd0);
      check($sformatf("reset_error_%0d", s), 32'(err[s]),   32'd0);
    end
    clear = 1'b1;

    for (int i = 0; i < vecs.size(); i++) run_txn(i, vecs[i]);

    // Busy/ready profile of a LATENCY=2 write: busy 3 cycles, ready only in the last.
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 9'h030, 32'h30303030);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      check($sformatf("profile_busy_c%0d", c),  32'(bsy[0]), 32'(c <= 3));
      check($sformatf("profile_ready_c%0d", c), 32'(rdy[0]), 32'(c == 3));
      if (c == 3) begin
        check("profile_error", 32'(err[0]), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 9'h000, 32'h0);
      end
    end
    $display("txn profile dut=a wr addr=030 -> busy 3 cycles, ready in cycle 3");

    // Address/data changed during WAIT must not affect the access.
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 9'h040, 32'hA5A5A5A5);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 9'h041, 32'hFFFFFFFF);
    cyc = 1;
    while (!rdy[0] && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("latch_cycles", 32'(cyc), 32'd3);
    drive(1'b0, 1'b0, 1'b0, 9'h000, 32'h0);
    $display("txn latch dut=a wr addr=040 (changed to 041 in WAIT) -> cycles=%0d", cyc);
    v = '{1'b0, 1'b1, 1'b0, 9'h040, 32'h0, 1'b0, 32'hA5A5A5A5};
    run_txn(100, v);
    v = '{1'b0, 1'b1, 1'b0, 9'h041, 32'h0, 1'b0, 32'h41414141};
    run_txn(101, v);

    // LATENCY=0 read held through RESP is not accepted again while in RESP.
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 9'h002, 32'h0);
    @(negedge clk);
    check("hold_ready_c1", 32'(rdy[1]), 32'd1);
    check("hold_data_c1",  dout[1],     32'h22222222);
    @(negedge clk);
    check("hold_ready_c2", 32'(rdy[1]), 32'd0);
    check("hold_busy_c2",  32'(bsy[1]), 32'd0);
    drive(1'b1, 1'b0, 1'b0, 9'h000, 32'h0);
    $display("txn hold dut=b rd addr=002 held -> single ready pulse");

    // Asynchronous reset during WAIT abandons the write to 0x020.
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 9'h020, 32'hFFFF0000);
    @(negedge clk);
    check("rst_busy_before", 32'(bsy[0]), 32'd1);
    #2 clear = 1'b0;
    #1;
    check("rst_busy_a",  32'(bsy[0]), 32'd0);
    check("rst_ready_a", 32'(rdy[0]), 32'd0);
    check("rst_error_a", 32'(err[0]), 32'd0);
    check("rst_data_a",  dout[0],     32'h0);
    check("rst_data_b",  dout[1],     32'h0);
    drive(1'b0, 1'b0, 1'b0, 9'h000, 32'h0);
    @(negedge clk);
    clear = 1'b1;
    $display("txn reset dut=a wr addr=020 interrupted in WAIT");
    v = '{1'b0, 1'b1, 1'b0, 9'h020, 32'h0, 1'b0, 32'h12345678};
    run_txn(102, v);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
